// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS-subset front end: opcodes, functs, ALU codes
// and the decoded control bundle passed from instr_decoder to decode_stage.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam int         ALU_CODE_W = 3;
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [1:0] {WR_RD, WR_RT, WR_RA} wr_sel_t;

    typedef enum logic {ST_RUN, ST_SQ} state_t;

    typedef struct packed {
        logic                  jump;
        logic                  jump_reg;
        logic                  branch;
        logic                  inv_zero;
        logic                  reg_write;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  alu_src;
        logic [ALU_CODE_W-1:0] alu_op;
        wr_sel_t               wr_sel;
    } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational opcode/funct decode into a control bundle; anything
// outside the supported subset raises illegal_o with an all-zero bundle.
module instr_decoder
    import mips_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        illegal_o
);

    logic [5:0] op;
    logic [5:0] funct;

    assign op    = instr_i[31:26];
    assign funct = instr_i[5:0];

    always_comb begin
        ctrl_o        = '0;
        ctrl_o.wr_sel = WR_RD;
        illegal_o     = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_ADD; end
                    FN_SUB: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_SUB; end
                    FN_SLT: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_SLT; end
                    FN_JR:  ctrl_o.jump_reg = 1'b1;
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_ADDI, OP_XORI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.wr_sel    = WR_RT;
                ctrl_o.alu_op    = (op == OP_XORI) ? ALU_XOR : ALU_ADD;
            end
            OP_LW: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.wr_sel     = WR_RT;
            end
            OP_SW: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
            end
            // Branch compare is rs - rt; Zero from the ALU resolves it.
            OP_BEQ, OP_BNE: begin
                ctrl_o.branch   = 1'b1;
                ctrl_o.inv_zero = (op == OP_BNE);
                ctrl_o.alu_op   = ALU_SUB;
            end
            OP_J: ctrl_o.jump = 1'b1;
            OP_JAL: begin
                ctrl_o.jump      = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wr_sel    = WR_RA;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// ID stage: aligns the registered memory word with its PC, drops wrong-path
// words behind a taken redirect, and registers the decoded ID/EX slot.
module decode_stage
    import mips_pkg::*;
#(
    parameter int SQUASH_DEPTH = 2,
    parameter int ALUOP_W      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        Instruction,
    input  logic [29:0]        PCin,
    input  logic               Zero,
    output logic               Valid,
    output logic               Jump,
    output logic               JumpReg,
    output logic               Branch,
    output logic               InvZero,
    output logic [25:0]        TargetInstr,
    output logic [15:0]        imm16,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               ALUSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [4:0]         Rs,
    output logic [4:0]         Rt,
    output logic [4:0]         WriteReg,
    output logic [31:0]        LinkAddr,
    output logic               Illegal
);

    localparam int CNT_W = (SQUASH_DEPTH > 1) ? $clog2(SQUASH_DEPTH + 1) : 1;

    ctrl_t  dec_ctrl;
    logic   dec_illegal;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  sqcnt_q, sqcnt_d;
    logic              fvalid_q;
    logic [29:0]       pc_q;
    logic              issue;
    logic              keep;
    logic              taken;
    logic [4:0]        wreg_d;

    logic               valid_q, jump_q, jump_reg_q, branch_q, inv_zero_q;
    logic               reg_write_q, mem_write_q, mem_to_reg_q, alu_src_q;
    logic               illegal_q;
    logic [ALUOP_W-1:0] alu_op_q;
    logic [25:0]        target_q;
    logic [15:0]        imm_q;
    logic [4:0]         rs_q, rt_q, wreg_q;
    logic [31:0]        link_q;

    instr_decoder u_dec (
        .instr_i   (Instruction),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    assign taken = valid_q & (jump_q | jump_reg_q | (branch_q & (Zero ^ inv_zero_q)));
    assign keep  = issue & ~dec_illegal;

    always_comb begin
        state_d = state_q;
        sqcnt_d = sqcnt_q;
        issue   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!fvalid_q) begin
                    issue = 1'b0;
                end else if (taken) begin
                    // The word behind the redirect is dropped now; the rest in SQ.
                    if (SQUASH_DEPTH > 1) begin
                        state_d = ST_SQ;
                        sqcnt_d = CNT_W'(SQUASH_DEPTH - 1);
                    end
                end else begin
                    issue = 1'b1;
                end
            end
            ST_SQ: begin
                sqcnt_d = sqcnt_q - 1'b1;
                if (sqcnt_q == CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        wreg_d = Instruction[15:11];
        case (dec_ctrl.wr_sel)
            WR_RT:   wreg_d = Instruction[20:16];
            WR_RA:   wreg_d = REG_RA;
            default: wreg_d = Instruction[15:11];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            sqcnt_q      <= '0;
            fvalid_q     <= 1'b0;
            pc_q         <= '0;
            valid_q      <= 1'b0;
            jump_q       <= 1'b0;
            jump_reg_q   <= 1'b0;
            branch_q     <= 1'b0;
            inv_zero_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= '0;
            illegal_q    <= 1'b0;
            target_q     <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            wreg_q       <= '0;
            link_q       <= '0;
        end else begin
            state_q      <= state_d;
            sqcnt_q      <= sqcnt_d;
            fvalid_q     <= 1'b1;
            pc_q         <= PCin;
            valid_q      <= keep;
            jump_q       <= keep & dec_ctrl.jump;
            jump_reg_q   <= keep & dec_ctrl.jump_reg;
            branch_q     <= keep & dec_ctrl.branch;
            inv_zero_q   <= keep & dec_ctrl.inv_zero;
            reg_write_q  <= keep & dec_ctrl.reg_write;
            mem_write_q  <= keep & dec_ctrl.mem_write;
            mem_to_reg_q <= keep & dec_ctrl.mem_to_reg;
            alu_src_q    <= keep & dec_ctrl.alu_src;
            alu_op_q     <= keep ? ALUOP_W'(dec_ctrl.alu_op) : '0;
            illegal_q    <= issue & dec_illegal;
            // Field outputs are don't-care in a bubble, so they load unconditionally.
            target_q     <= Instruction[25:0];
            imm_q        <= Instruction[15:0];
            rs_q         <= Instruction[25:21];
            rt_q         <= Instruction[20:16];
            wreg_q       <= wreg_d;
            link_q       <= {pc_q + 30'd1, 2'b00};
        end
    end

    assign Valid       = valid_q;
    assign Jump        = jump_q;
    assign JumpReg     = jump_reg_q;
    assign Branch      = branch_q;
    assign InvZero     = inv_zero_q;
    assign RegWrite    = reg_write_q;
    assign MemWrite    = mem_write_q;
    assign MemToReg    = mem_to_reg_q;
    assign ALUSrc      = alu_src_q;
    assign ALUOp       = alu_op_q;
    assign Illegal     = illegal_q;
    assign TargetInstr = target_q;
    assign imm16       = imm_q;
    assign Rs          = rs_q;
    assign Rt          = rt_q;
    assign WriteReg    = wreg_q;
    assign LinkAddr    = link_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: a small instruction memory feeds the
// stage with mem[previous PCin], and each captured slot is checked by hand.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instruction;
    logic [29:0] PCin;
    logic        Zero;
    logic        Valid, Jump, JumpReg, Branch, InvZero;
    logic [25:0] TargetInstr;
    logic [15:0] imm16;
    logic        RegWrite, MemWrite, MemToReg, ALUSrc;
    logic [2:0]  ALUOp;
    logic [4:0]  Rs, Rt, WriteReg;
    logic [31:0] LinkAddr;
    logic        Illegal;

    logic [31:0] mem [0:63];
    logic [29:0] last_pc;
    int          errors = 0;
    int          checks = 0;

    // Control vector order: Valid Jump JumpReg Branch InvZero RegWrite MemWrite MemToReg ALUSrc Illegal
    logic [9:0] ctl;
    assign ctl = {Valid, Jump, JumpReg, Branch, InvZero, RegWrite, MemWrite, MemToReg, ALUSrc, Illegal};

    always #5 clk = ~clk;

    decode_stage #(.SQUASH_DEPTH(2), .ALUOP_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .Instruction (Instruction),
        .PCin        (PCin),
        .Zero        (Zero),
        .Valid       (Valid),
        .Jump        (Jump),
        .JumpReg     (JumpReg),
        .Branch      (Branch),
        .InvZero     (InvZero),
        .TargetInstr (TargetInstr),
        .imm16       (imm16),
        .RegWrite    (RegWrite),
        .MemWrite    (MemWrite),
        .MemToReg    (MemToReg),
        .ALUSrc      (ALUSrc),
        .ALUOp       (ALUOp),
        .Rs          (Rs),
        .Rt          (Rt),
        .WriteReg    (WriteReg),
        .LinkAddr    (LinkAddr),
        .Illegal     (Illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One fetch cycle: memory returns the word for last cycle's PC, PCin is the new PC.
    task automatic step(input logic [29:0] pc, input logic z);
        Instruction = mem[last_pc];
        PCin        = pc;
        Zero        = z;
        @(posedge clk);
        #1;
        $display("t=%0t pcin=%0d instr=%08h -> valid=%0b ctl=%010b aluop=%0d", $time, pc,
                 Instruction, Valid, ctl, ALUOp);
        last_pc = pc;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h20010005;  // addi $1,$0,5
        mem[1]  = 32'h08000009;  // j 9
        mem[9]  = 32'h10220003;  // beq $1,$2,3
        mem[13] = 32'h10220003;  // beq $1,$2,3
        mem[14] = 32'h14640002;  // bne $3,$4,2
        mem[16] = 32'h2002FFFF;  // addi $2,$0,-1
        mem[17] = 32'h14640002;  // bne $3,$4,2
        mem[18] = 32'hACC50008;  // sw $5,8($6)
        mem[19] = 32'h8CC70004;  // lw $7,4($6)
        mem[20] = 32'h00224022;  // sub $8,$1,$2
        mem[21] = 32'h0022482A;  // slt $9,$1,$2
        mem[22] = 32'h382A00FF;  // xori $10,$1,0xFF
        mem[23] = 32'h0022483F;  // R-type, bad funct
        mem[24] = 32'h03E00008;  // jr $31
        mem[4]  = 32'h0C000010;  // jal 0x10
        mem[48] = 32'hFC000000;  // opcode 0x3F

        reset = 1'b1; Instruction = '0; PCin = '0; Zero = 1'b0; last_pc = '0;
        step(0, 0);
        step(0, 0);
        check("reset_ctl", 32'(ctl), 32'h0);
        check("reset_link", LinkAddr, 32'h0);
        reset = 1'b0;

        step(0, 0);
        check("post_reset_bubble", 32'(ctl), 32'h0);
        step(1, 0);
        check("addi_ctl", 32'(ctl), 32'b1000010010);
        check("addi_wreg", 32'(WriteReg), 32'd1);
        check("addi_imm", 32'(imm16), 32'd5);
        check("addi_aluop", 32'(ALUOp), 32'd0);

        step(2, 0);
        check("j_ctl", 32'(ctl), 32'b1100000000);
        check("j_target", 32'(TargetInstr), 32'd9);
        step(3, 0);
        check("j_squash1", 32'(ctl), 32'h0);
        step(9, 0);
        check("j_squash2", 32'(ctl), 32'h0);
        step(10, 0);
        check("beq_ctl", 32'(ctl), 32'b1001000000);
        check("beq_aluop", 32'(ALUOp), 32'd1);
        check("beq_rs_rt", 32'({Rs, Rt}), 32'({5'd1, 5'd2}));

        step(11, 1);
        check("beq_taken_sq1", 32'(ctl), 32'h0);
        step(13, 0);
        check("beq_taken_sq2", 32'(ctl), 32'h0);
        step(14, 0);
        check("beq2_ctl", 32'(ctl), 32'b1001000000);
        step(15, 0);
        check("beq_nt_next_ctl", 32'(ctl), 32'b1001100000);
        check("bne_imm", 32'(imm16), 32'd2);

        step(16, 0);
        check("bne_taken_sq1", 32'(ctl), 32'h0);
        step(17, 0);
        check("bne_taken_sq2", 32'(ctl), 32'h0);
        step(18, 0);
        check("bne2_ctl", 32'(ctl), 32'b1001100000);
        step(19, 1);
        check("sw_ctl", 32'(ctl), 32'b1000001010);
        step(20, 0);
        check("lw_ctl", 32'(ctl), 32'b1000010110);
        check("lw_wreg", 32'(WriteReg), 32'd7);
        step(21, 0);
        check("sub_ctl", 32'(ctl), 32'b1000010000);
        check("sub_aluop", 32'(ALUOp), 32'd1);
        check("sub_wreg", 32'(WriteReg), 32'd8);
        step(22, 0);
        check("slt_aluop", 32'(ALUOp), 32'd3);
        check("slt_wreg", 32'(WriteReg), 32'd9);
        step(23, 0);
        check("xori_ctl", 32'(ctl), 32'b1000010010);
        check("xori_aluop", 32'(ALUOp), 32'd2);
        check("xori_wreg_imm", {11'd0, WriteReg, imm16}, {11'd0, 5'd10, 16'h00FF});
        step(24, 0);
        check("bad_funct_ctl", 32'(ctl), 32'b0000000001);
        step(25, 0);
        check("jr_ctl", 32'(ctl), 32'b1010000000);
        check("jr_rs", 32'(Rs), 32'd31);

        step(26, 0);
        check("jr_squash1", 32'(ctl), 32'h0);
        reset = 1'b1;
        step(27, 0);
        check("reset_mid_squash", 32'(ctl), 32'h0);
        check("reset_mid_squash_link", LinkAddr, 32'h0);
        reset = 1'b0;
        step(4, 0);
        check("rerun_bubble", 32'(ctl), 32'h0);
        step(5, 0);
        check("jal_ctl", 32'(ctl), 32'b1100010000);
        check("jal_wreg", 32'(WriteReg), 32'd31);
        check("jal_link", LinkAddr, 32'h14);
        check("jal_target", 32'(TargetInstr), 32'h10);

        step(6, 0);
        check("jal_squash1", 32'(ctl), 32'h0);
        step(16, 0);
        check("jal_squash2", 32'(ctl), 32'h0);
        step(17, 0);
        check("addi_neg_ctl", 32'(ctl), 32'b1000010010);
        check("addi_neg_imm", 32'(imm16), 32'hFFFF);
        check("addi_neg_wreg", 32'(WriteReg), 32'd2);
        step(18, 0);
        check("bne3_ctl", 32'(ctl), 32'b1001100000);
        step(48, 1);
        check("sw2_ctl", 32'(ctl), 32'b1000001010);
        step(49, 0);
        check("bad_op_ctl", 32'(ctl), 32'b0000000001);
        step(50, 0);
        check("after_illegal_ctl", 32'(ctl), 32'b1000010010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
